// File: rtl/audio_fir_pkg.sv
// Shared defaults and FSM encoding for the audio moving-average FIR stage.
package audio_fir_pkg;

    localparam int unsigned FIR_DW        = 24;
    localparam int unsigned FIR_TAPS      = 8;
    localparam int unsigned FIR_LOG2_TAPS = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        WAIT_WR = 2'd2,
        WRITE   = 2'd3
    } fir_state_t;

endpackage

// File: rtl/fir_tap_buffer.sv
// Per-channel circular sample buffer: one write port, one indexed
// combinational read port, synchronous clear of every entry.
module fir_tap_buffer
    import audio_fir_pkg::*;
#(
    parameter int unsigned DW    = FIR_DW,
    parameter int unsigned DEPTH = FIR_TAPS,
    parameter int unsigned AW    = FIR_LOG2_TAPS
) (
    input  logic          CLOCK_50,
    input  logic          clear,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // Clear wipes the whole history; otherwise store the captured sample.
    always_ff @(posedge CLOCK_50) begin
        if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/audio_fir_stage.sv
// Stereo moving-average FIR stage between a codec ADC and DAC: capture a
// sample pair, sum the last TAPS samples per channel, divide by TAPS via
// arithmetic shift, then hand the pair back to the codec.
module audio_fir_stage
    import audio_fir_pkg::*;
#(
    parameter int unsigned DW        = FIR_DW,
    parameter int unsigned TAPS      = FIR_TAPS,
    parameter int unsigned LOG2_TAPS = FIR_LOG2_TAPS
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          read_ready,
    input  logic [DW-1:0] readdata_left,
    input  logic [DW-1:0] readdata_right,
    output logic          read,
    input  logic          write_ready,
    output logic [DW-1:0] writedata_left,
    output logic [DW-1:0] writedata_right,
    output logic          write,
    output logic          busy
);

    localparam int unsigned AW = DW + LOG2_TAPS;

    fir_state_t            state;
    logic [LOG2_TAPS-1:0]  wr_ptr;
    logic [LOG2_TAPS-1:0]  tap_idx;
    logic                  capture;
    logic [DW-1:0]         tap_left;
    logic [DW-1:0]         tap_right;
    logic signed [AW-1:0]  acc_left;
    logic signed [AW-1:0]  acc_right;
    logic [DW-1:0]         avg_left;
    logic [DW-1:0]         avg_right;

    // Buffer clear shares the reset, so it has priority over a capture.
    assign capture = (state == IDLE) && read_ready;

    fir_tap_buffer #(
        .DW    (DW),
        .DEPTH (TAPS),
        .AW    (LOG2_TAPS)
    ) u_buf_left (
        .CLOCK_50 (CLOCK_50),
        .clear    (reset),
        .we       (capture),
        .wr_addr  (wr_ptr),
        .wr_data  (readdata_left),
        .rd_addr  (tap_idx),
        .rd_data  (tap_left)
    );

    fir_tap_buffer #(
        .DW    (DW),
        .DEPTH (TAPS),
        .AW    (LOG2_TAPS)
    ) u_buf_right (
        .CLOCK_50 (CLOCK_50),
        .clear    (reset),
        .we       (capture),
        .wr_addr  (wr_ptr),
        .wr_data  (readdata_right),
        .rd_addr  (tap_idx),
        .rd_data  (tap_right)
    );

    // Divide by TAPS with floor rounding, keep the low DW bits.
    assign avg_left  = DW'(acc_left  >>> LOG2_TAPS);
    assign avg_right = DW'(acc_right >>> LOG2_TAPS);

    // Control FSM with registered handshake outputs and accumulators.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            tap_idx         <= '0;
            acc_left        <= '0;
            acc_right       <= '0;
            writedata_left  <= '0;
            writedata_right <= '0;
            read            <= 1'b0;
            write           <= 1'b0;
            busy            <= 1'b0;
        end else begin
            read  <= 1'b0;
            write <= 1'b0;
            case (state)
                IDLE: begin
                    if (read_ready) begin
                        wr_ptr    <= wr_ptr + 1'b1;
                        tap_idx   <= '0;
                        acc_left  <= '0;
                        acc_right <= '0;
                        read      <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_left  <= acc_left  + {{LOG2_TAPS{tap_left[DW-1]}},  tap_left};
                    acc_right <= acc_right + {{LOG2_TAPS{tap_right[DW-1]}}, tap_right};
                    if (tap_idx == LOG2_TAPS'(TAPS - 1)) begin
                        state <= WAIT_WR;
                    end else begin
                        tap_idx <= tap_idx + 1'b1;
                    end
                end
                WAIT_WR: begin
                    if (write_ready) begin
                        writedata_left  <= avg_left;
                        writedata_right <= avg_right;
                        write           <= 1'b1;
                        state           <= WRITE;
                    end
                end
                WRITE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_fir_stage.sv
// Self-checking bench for audio_fir_stage: a history-based moving-average
// model predicts every DAC pair; directed vectors pin known outputs.
module tb_audio_fir_stage;

    localparam int DW        = 24;
    localparam int TAPS      = 8;
    localparam int LOG2_TAPS = 3;

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b1;
    logic          read_ready = 1'b0;
    logic          write_ready = 1'b1;
    logic [DW-1:0] readdata_left = '0;
    logic [DW-1:0] readdata_right = '0;
    logic          read;
    logic          write;
    logic          busy;
    logic [DW-1:0] writedata_left;
    logic [DW-1:0] writedata_right;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    logic [DW-1:0] last_l = '0;
    logic [DW-1:0] last_r = '0;
    logic [DW-1:0] exp_l_q[$];
    logic [DW-1:0] exp_r_q[$];
    int hist_l[$];
    int hist_r[$];

    audio_fir_stage #(
        .DW        (DW),
        .TAPS      (TAPS),
        .LOG2_TAPS (LOG2_TAPS)
    ) dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .read_ready      (read_ready),
        .readdata_left   (readdata_left),
        .readdata_right  (readdata_right),
        .read            (read),
        .write_ready     (write_ready),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .write           (write),
        .busy            (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_int(input logic [DW-1:0] x);
        logic signed [DW-1:0] s;
        s = x;
        return int'(s);
    endfunction

    // Mean of the last TAPS samples (missing history counts as zero),
    // rounded toward minus infinity, wrapped to DW bits.
    function automatic logic [DW-1:0] model_avg(input bit right);
        longint sum;
        longint q;
        sum = 0;
        for (int i = 0; i < TAPS; i++) begin
            if (right) begin
                if (i < hist_r.size()) sum += hist_r[i];
            end else begin
                if (i < hist_l.size()) sum += hist_l[i];
            end
        end
        q = sum / TAPS;
        if (sum < 0 && (sum % TAPS) != 0) q = q - 1;
        return q[DW-1:0];
    endfunction

    // Every cycle: DAC data must hold the most recently written pair.
    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            if (write) begin
                if (exp_l_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: write=1 got, write=0 expected at %0t", $time);
                end else begin
                    last_l = exp_l_q.pop_front();
                    last_r = exp_r_q.pop_front();
                end
            end
            check("writedata", {writedata_left, writedata_right}, {last_l, last_r});
            check("read_write_excl", 64'(read & write), 64'd0);
        end
    end

    task automatic do_reset();
        @(negedge CLOCK_50);
        chk_en = 1'b0;
        reset = 1'b1;
        read_ready = 1'b0;
        write_ready = 1'b1;
        hist_l.delete();
        hist_r.delete();
        exp_l_q.delete();
        exp_r_q.delete();
        @(negedge CLOCK_50);
        check("reset_state", {read, write, busy, writedata_left, writedata_right}, 64'd0);
        last_l = '0;
        last_r = '0;
        reset = 1'b0;
        chk_en = 1'b1;
    endtask

    // Presents a pair to an idle DUT; returns at the negedge after capture.
    task automatic start_capture(input logic [DW-1:0] l, input logic [DW-1:0] r, input int wr_delay);
        @(negedge CLOCK_50);
        read_ready = 1'b1;
        readdata_left = l;
        readdata_right = r;
        write_ready = (wr_delay == 0);
        hist_l.push_front(to_int(l));
        hist_r.push_front(to_int(r));
        if (hist_l.size() > TAPS) void'(hist_l.pop_back());
        if (hist_r.size() > TAPS) void'(hist_r.pop_back());
        exp_l_q.push_back(model_avg(1'b0));
        exp_r_q.push_back(model_avg(1'b1));
        @(negedge CLOCK_50);
        check("read_pulse", 64'(read), 64'd1);
    endtask

    task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r, input int wr_delay,
                        input bit hold_rr, input bit use_lit,
                        input logic [DW-1:0] lit_l, input logic [DW-1:0] lit_r);
        int exp_k;
        bit seen;
        start_capture(l, r, wr_delay);
        if (!hold_rr) read_ready = 1'b0;
        readdata_left = DW'($urandom);
        readdata_right = DW'($urandom);
        exp_k = (wr_delay + 1 > TAPS + 2) ? wr_delay + 1 : TAPS + 2;
        seen = 1'b0;
        for (int k = 1; k <= 400 && !seen; k++) begin
            if (k > 1) @(negedge CLOCK_50);
            if (write) begin
                seen = 1'b1;
                check("latency", 64'(k), 64'(exp_k));
                if (use_lit) check("literal_out", {writedata_left, writedata_right}, {lit_l, lit_r});
                read_ready = 1'b0;
            end else begin
                if (k > 1) check("read_quiet", 64'(read), 64'd0);
                check("busy", 64'(busy), 64'd1);
            end
            if (wr_delay > 0 && k == wr_delay) write_ready = 1'b1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL write_timeout: write=0 got, write=1 expected within 400 cycles");
            read_ready = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int m;
        logic [DW-1:0] v;

        do_reset();

        // Constant 0x000800: ramp up by 0x100 per sample, then steady.
        for (int n = 1; n <= 10; n++) begin
            m = (n < TAPS) ? n : TAPS;
            v = DW'(m * 256);
            send(24'h000800, 24'h000800, 0, 1'b0, 1'b1, v, v);
        end

        // Impulse: eight outputs of 0x010000, then zero.
        do_reset();
        for (int n = 1; n <= 10; n++) begin
            v = (n <= TAPS) ? 24'h010000 : 24'h000000;
            send((n == 1) ? 24'h080000 : 24'h000000, (n == 1) ? 24'h080000 : 24'h000000,
                 0, 1'b0, 1'b1, v, v);
        end

        // Constant -8: floor rounding gives -1, -2, ... settling at -8.
        do_reset();
        for (int n = 1; n <= 9; n++) begin
            m = (n < TAPS) ? n : TAPS;
            v = DW'(-m);
            send(24'hFFFFF8, 24'hFFFFF8, 0, 1'b0, 1'b1, v, v);
        end

        // Opposite-sign channels stay independent.
        do_reset();
        send(24'h000800, 24'hFFF800, 0, 1'b0, 1'b1, 24'h000100, 24'hFFFF00);

        // Long DAC back-pressure with the ADC still offering data.
        send(24'h000800, 24'hFFF800, 200, 1'b1, 1'b1, 24'h000200, 24'hFFFE00);

        // Reset during the 4th accumulate cycle aborts and clears history.
        do_reset();
        send(24'h000800, 24'h000800, 0, 1'b0, 1'b0, '0, '0);
        start_capture(24'h123456, 24'h654321, 0);
        read_ready = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        do_reset();
        repeat (20) @(negedge CLOCK_50);
        check("abort_idle", {63'd0, busy}, 64'd0);
        send(24'h000800, 24'h000800, 0, 1'b0, 1'b1, 24'h000100, 24'h000100);

        // Full-scale extremes and random traffic against the model.
        send(24'h7FFFFF, 24'h800000, 0, 1'b0, 1'b0, '0, '0);
        send(24'h7FFFFF, 24'h800000, 5, 1'b1, 1'b0, '0, '0);
        for (int n = 0; n < 12; n++) begin
            send(DW'($urandom), DW'($urandom), int'($urandom_range(0, 12)),
                 1'($urandom_range(0, 1)), 1'b0, '0, '0);
        end

        repeat (4) @(negedge CLOCK_50);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
